boreal_ledger_slave: RTL and testbench
======================================

# boreal_ledger_slave

Append-only audit ledger that sits on the interconnect's `ledger_*` slave port, the responder end of that select/ack protocol. It accepts 32-bit append writes into an on-chip log and supports indexed readback. It also provides count, status and seal registers, plus an optional running chain digest. Responses are registered and pulse `ledger_ack` once per transaction, so the interconnect's held-request handshake completes deterministically.

## Interface
- `DEPTH`, 64: number of log entries; power of two, 4 to 1024.
- `IDX_W`, `$clog2(DEPTH)`: entry index width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `ledger_sel` in 1: transaction request; held by the interconnect until ack.
- `ledger_wr` in 1: 1 = write, 0 = read.
- `ledger_addr` in 32: byte address; only `[7:0]` is decoded.
- `ledger_wdata` in 32: write data.
- `ledger_rdata` out 32: read data; valid only while `ledger_ack` = 1, otherwise 0.
- `ledger_ack` out 1: one-cycle response pulse.

## Operation
Register map (offsets in `addr[7:0]`):
- `0x00` APPEND (W): when not full and not sealed, store `wdata` at `wr_ptr`, increment `wr_ptr` and `count`, and update the digest. Otherwise drop the write and set OVF.
- `0x04` COUNT (R): `count`, zero-extended; range 0..DEPTH.
- `0x08` HEAD (R): current digest.
- `0x0C` STATUS (R): bit0 FULL (`count` == DEPTH), bit1 OVF (sticky), bit2 SEALED. Writing 1 to bit1 clears OVF.
- `0x10` SEAL (W): `wdata[7:0]` == 0xA5 sets SEALED; any other value is ignored. SEALED clears only on reset.
- `0x14` RD_IDX (W): `rd_idx <= wdata[IDX_W-1:0]`. Reads back the same value zero-extended.
- `0x18` RD_DATA (R): the log entry at `rd_idx`. An index ≥ `count` returns 0.

General rules:
- Writes to read-only offsets and accesses to unmapped offsets are ignored, still acked, and read 0. The slave port has no error signal.
- Log storage is a synchronous-read RAM (1 write port, 1 read port) and is not reset.
- FSM states: IDLE, RAM_RD, RESP.
  - IDLE, `sel` = 1, read of RD_DATA → RAM_RD (RAM address presented).
  - IDLE, `sel` = 1, any other access → RESP. Write side-effects are committed on this edge and read data is registered.
  - RAM_RD → RESP, capturing RAM output.
  - RESP → IDLE unconditionally, with `ack` = 1 in RESP.
- Side-effects occur exactly once per transaction, on the IDLE→* edge.
- If `sel` drops mid-transaction, the transaction still completes and acks. Address and data are latched at IDLE.
- Each accepted append writes `ledger_wdata` into the RAM entry at `wr_ptr` in the IDLE→RESP cycle.
- Digest update, all arithmetic mod 2^32: `digest <= ({digest[26:0],digest[31:27]} ^ wdata) + 32'h9E37_79B9`. Seed on reset is `32'h6A09_E667`.
- `wr_ptr` never wraps. Once FULL, appends are rejected.

## Timing
- Reset values: `ledger_ack` = 0, `ledger_rdata` = 0, state = IDLE, `count` = 0, `wr_ptr` = 0, `rd_idx` = 0, OVF = 0, SEALED = 0, digest = seed.
- Reset asserted mid-transaction aborts it: no ack, and outputs go to reset values asynchronously.
- Latency, with `sel` sampled high in IDLE at edge N:
  - Register access: `ack` is high during cycle N+1.
  - RD_DATA: `ack` is high during cycle N+2.
- Minimum spacing between transactions: 2 cycles for register accesses, 3 for RD_DATA. The IDLE cycle after RESP is mandatory, so a `sel` held through ack is not re-accepted in the RESP cycle.
- An append and a readback of the same index in successive transactions return the new data. A write is always committed at least one cycle before any later RAM read.

## Configuration
- `BOREAL_LEDGER_DIGEST_EN`
  - Defined: the digest register and update logic are present, and HEAD returns the digest.
  - Undefined: no digest logic is present, HEAD reads 0, and all other behaviour is identical.

## Structure
- Shared package `boreal_pkg.v` holds:
  - Offset constants `LEDGER_OFF_APPEND`, `LEDGER_OFF_COUNT`, `LEDGER_OFF_HEAD`, `LEDGER_OFF_STATUS`, `LEDGER_OFF_SEAL`, `LEDGER_OFF_RDIDX`, `LEDGER_OFF_RDDATA`.
  - `LEDGER_SEAL_KEY` (8'hA5), `LEDGER_DIGEST_SEED`, `LEDGER_DIGEST_K`.
  - FSM state encodings.
- One sub-module: `boreal_ledger_ram` (DEPTH×32, synchronous read, no reset). It maps onto an SRAM macro later.

## Test plan
- Reset, then read STATUS and COUNT → `ack` exactly 1 cycle after `sel` is sampled, STATUS = 0x0 and COUNT = 0x0. With `DIGEST_EN` defined, HEAD = 0x6A09E667.
- Append 0x0000_0001 → COUNT = 1 and HEAD = 0xDF7446A5. Write RD_IDX = 0, then read RD_DATA → 0x0000_0001 with `ack` 2 cycles after sample.
- Append DEPTH words, then one more → COUNT = DEPTH and STATUS = 0x3. Write STATUS bit1 → STATUS = 0x1.
- Write SEAL 0x5A → SEALED = 0. Write SEAL 0xA5 → STATUS bit2 = 1. A further append leaves COUNT unchanged and sets OVF.
- Hold `sel` continuously across 3 register reads → exactly one ack per transaction, separated by one IDLE cycle. Drop `sel` the cycle after sample → ack still pulses once. Read unmapped offset 0xFC → rdata 0, ack 1.
- Assert `rst` while in RAM_RD → `ack` never rises. Afterwards COUNT = 0, SEALED = 0 and HEAD = seed.

Source files
------------

// File: rtl/boreal_pkg.sv
// Shared constants for the boreal ledger slave: register offsets, seal key, digest constants, FSM encoding.
// Latency: n/a (package only).  Backpressure: n/a.
package boreal_pkg;

    localparam logic [7:0] LEDGER_OFF_APPEND = 8'h00;
    localparam logic [7:0] LEDGER_OFF_COUNT  = 8'h04;
    localparam logic [7:0] LEDGER_OFF_HEAD   = 8'h08;
    localparam logic [7:0] LEDGER_OFF_STATUS = 8'h0C;
    localparam logic [7:0] LEDGER_OFF_SEAL   = 8'h10;
    localparam logic [7:0] LEDGER_OFF_RDIDX  = 8'h14;
    localparam logic [7:0] LEDGER_OFF_RDDATA = 8'h18;

    localparam logic [7:0]  LEDGER_SEAL_KEY    = 8'hA5;
    localparam logic [31:0] LEDGER_DIGEST_SEED = 32'h6A09_E667;
    localparam logic [31:0] LEDGER_DIGEST_K    = 32'h9E37_79B9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAM_RD = 2'd1,
        ST_RESP   = 2'd2
    } ledger_state_e;

    // Rotate-left-5, xor in the appended word, add the golden-ratio constant.
    function automatic logic [31:0] ledger_digest_next(input logic [31:0] d, input logic [31:0] w);
        return ({d[26:0], d[31:27]} ^ w) + LEDGER_DIGEST_K;
    endfunction

endpackage

// File: rtl/boreal_ledger_ram.sv
// DEPTH x 32 log storage, one write port and one synchronous read port, no reset (SRAM macro candidate).
// Latency: read data valid the cycle after re.  Backpressure: none, always ready.
module boreal_ledger_ram #(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata_q
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

endmodule

// File: rtl/boreal_ledger_slave.sv
// Append-only audit ledger on the ledger_* sel/ack slave port; optional digest via BOREAL_LEDGER_DIGEST_EN.
// Latency: ack one cycle after sel is sampled, two for RD_DATA.  Backpressure: sel held until ack; one IDLE cycle between transactions.
module boreal_ledger_slave
    import boreal_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ledger_sel,
    input  logic        ledger_wr,
    input  logic [31:0] ledger_addr,
    input  logic [31:0] ledger_wdata,
    output logic [31:0] ledger_rdata,
    output logic        ledger_ack
);

    localparam int CNT_W = IDX_W + 1;

    ledger_state_e    state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic             ovf_q, ovf_d;
    logic             sealed_q, sealed_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      head;
    logic [31:0]      ram_rdata;
    logic [31:0]      reg_rdata;
    logic             append_ok;
    logic             ram_re;
    logic             full;
    logic             is_rddata;
    logic [7:0]       off;
    logic [23:0]      addr_unused;

    assign off         = ledger_addr[7:0];
    assign addr_unused = ledger_addr[31:8];
    assign full        = (count_q == CNT_W'(DEPTH));
    assign is_rddata   = !ledger_wr && (off == LEDGER_OFF_RDDATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (ledger_sel) state_d = is_rddata ? ST_RAM_RD : ST_RESP;
            ST_RAM_RD: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        reg_rdata = '0;
        case (off)
            LEDGER_OFF_COUNT:  reg_rdata = 32'(count_q);
            LEDGER_OFF_HEAD:   reg_rdata = head;
            LEDGER_OFF_STATUS: reg_rdata = {29'b0, sealed_q, ovf_q, full};
            LEDGER_OFF_RDIDX:  reg_rdata = 32'(rd_idx_q);
            default:           reg_rdata = '0;
        endcase
    end

    // All side-effects land on the edge leaving IDLE, so each transaction commits exactly once.
    always_comb begin
        count_d   = count_q;
        rd_idx_d  = rd_idx_q;
        ovf_d     = ovf_q;
        sealed_d  = sealed_q;
        ack_d     = 1'b0;
        rdata_d   = '0;
        append_ok = 1'b0;
        ram_re    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ledger_sel) begin
                    if (is_rddata) begin
                        ram_re = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                        if (ledger_wr) begin
                            case (off)
                                LEDGER_OFF_APPEND: begin
                                    if (!full && !sealed_q) begin
                                        append_ok = 1'b1;
                                        count_d   = count_q + CNT_W'(1);
                                    end else begin
                                        ovf_d = 1'b1;
                                    end
                                end
                                LEDGER_OFF_STATUS: if (ledger_wdata[1]) ovf_d = 1'b0;
                                LEDGER_OFF_SEAL:   if (ledger_wdata[7:0] == LEDGER_SEAL_KEY) sealed_d = 1'b1;
                                LEDGER_OFF_RDIDX:  rd_idx_d = ledger_wdata[IDX_W-1:0];
                                default: ;
                            endcase
                        end else begin
                            rdata_d = reg_rdata;
                        end
                    end
                end
            end
            ST_RAM_RD: begin
                ack_d   = 1'b1;
                rdata_d = ({1'b0, rd_idx_q} < count_q) ? ram_rdata : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            rd_idx_q <= '0;
            ovf_q    <= 1'b0;
            sealed_q <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            count_q  <= count_d;
            rd_idx_q <= rd_idx_d;
            ovf_q    <= ovf_d;
            sealed_q <= sealed_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef BOREAL_LEDGER_DIGEST_EN
    logic [31:0] digest_q, digest_d;

    always_comb begin
        digest_d = digest_q;
        if (append_ok) digest_d = ledger_digest_next(digest_q, ledger_wdata);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) digest_q <= LEDGER_DIGEST_SEED;
        else     digest_q <= digest_d;
    end

    assign head = digest_q;
`else
    assign head = '0;
`endif

    // wr_ptr never wraps and always equals count, so the low count bits address the RAM.
    boreal_ledger_ram #(
        .DEPTH(DEPTH),
        .IDX_W(IDX_W)
    ) u_ram (
        .clk    (clk),
        .we     (append_ok),
        .waddr  (count_q[IDX_W-1:0]),
        .wdata  (ledger_wdata),
        .re     (ram_re),
        .raddr  (rd_idx_q),
        .rdata_q(ram_rdata)
    );

    assign ledger_ack   = ack_q;
    assign ledger_rdata = rdata_q;

endmodule

// File: tb/tb_boreal_ledger_slave.sv
// Bench for boreal_ledger_slave: vector table plus hand-written multi-cycle sequences, scoreboard on ack.
module tb_boreal_ledger_slave;
    import boreal_pkg::*;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

`ifdef BOREAL_LEDGER_DIGEST_EN
    localparam logic [31:0] HEAD0 = 32'h6A09_E667;
    localparam logic [31:0] HEAD1 = 32'hDF74_46A5;
    localparam bit          DIG   = 1'b1;
`else
    localparam logic [31:0] HEAD0 = 32'h0;
    localparam logic [31:0] HEAD1 = 32'h0;
    localparam bit          DIG   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack;

    always #5 clk = ~clk;

    boreal_ledger_slave #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ledger_sel  (sel),
        .ledger_wr   (wr),
        .ledger_addr (addr),
        .ledger_wdata(wdata),
        .ledger_rdata(rdata),
        .ledger_ack  (ack)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    exp_t        sb[$];
    exp_t        e_pop;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_head;

    function automatic logic [31:0] dig_step(input logic [31:0] d, input logic [31:0] w);
        return ({d[26:0], d[31:27]} ^ w) + 32'h9E37_79B9;
    endfunction

    // Monitor: every ack must match the oldest expectation in cycle and data; rdata must be 0 otherwise.
    always @(negedge clk) begin
        if (ack) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack cyc=%0d rdata=%h required=no_ack", cyc, rdata);
            end else begin
                e_pop = sb.pop_front();
                if (cyc != e_pop.cyc || rdata !== e_pop.data) begin
                    errors++;
                    $display("FAIL resp cyc=%0d rdata=%h required cyc=%0d rdata=%h", cyc, rdata, e_pop.cyc, e_pop.data);
                end
            end
        end else if (!rst) begin
            checks++;
            if (rdata !== 32'h0) begin
                errors++;
                $display("FAIL rdata_idle cyc=%0d rdata=%h required=0", cyc, rdata);
            end
        end
    end

    task automatic txn(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input bit early_drop);
        exp_t e;
        bit   got;
        @(negedge clk);
        sel   = 1'b1;
        wr    = w;
        addr  = {24'h0, a};
        wdata = d;
        e.cyc  = cyc + ((!w && a == LEDGER_OFF_RDDATA) ? 2 : 1);
        e.data = exp;
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (early_drop) sel = 1'b0;
            if (ack) got = 1'b1;
        end
        sel = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout addr=%h ack=0 required=1", a);
            sb.delete();
        end
    endtask

    task automatic wreg(input logic [7:0] a, input logic [31:0] d);
        txn(1'b1, a, d, 32'h0, 1'b0);
    endtask

    task automatic rchk(input logic [7:0] a, input logic [31:0] exp);
        txn(1'b0, a, 32'h0, exp, 1'b0);
    endtask

    task automatic append(input logic [31:0] d, input bit accepted);
        wreg(LEDGER_OFF_APPEND, d);
        if (accepted && DIG) model_head = dig_step(model_head, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[16];
        int   c;

        vt[0]  = '{1'b0, LEDGER_OFF_COUNT,  32'h0,  32'h0};
        vt[1]  = '{1'b0, LEDGER_OFF_STATUS, 32'h0,  32'h0};
        vt[2]  = '{1'b0, LEDGER_OFF_HEAD,   32'h0,  HEAD0};
        vt[3]  = '{1'b1, LEDGER_OFF_APPEND, 32'h1,  32'h0};
        vt[4]  = '{1'b0, LEDGER_OFF_COUNT,  32'h0,  32'h1};
        vt[5]  = '{1'b0, LEDGER_OFF_HEAD,   32'h0,  HEAD1};
        vt[6]  = '{1'b1, LEDGER_OFF_RDIDX,  32'h0,  32'h0};
        vt[7]  = '{1'b0, LEDGER_OFF_RDDATA, 32'h0,  32'h1};
        vt[8]  = '{1'b1, LEDGER_OFF_RDIDX,  32'h3,  32'h0};
        vt[9]  = '{1'b0, LEDGER_OFF_RDIDX,  32'h0,  32'h3};
        vt[10] = '{1'b0, LEDGER_OFF_RDDATA, 32'h0,  32'h0};
        vt[11] = '{1'b0, 8'hFC,             32'h0,  32'h0};
        vt[12] = '{1'b1, LEDGER_OFF_COUNT,  32'h5,  32'h0};
        vt[13] = '{1'b0, LEDGER_OFF_COUNT,  32'h0,  32'h1};
        vt[14] = '{1'b1, LEDGER_OFF_SEAL,   32'h5A, 32'h0};
        vt[15] = '{1'b0, LEDGER_OFF_STATUS, 32'h0,  32'h0};

        repeat (3) @(negedge clk);
        checks++;
        if (ack !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs ack=%b rdata=%h required ack=0 rdata=0", ack, rdata);
        end
        rst = 1'b0;
        model_head = HEAD1;

        for (int i = 0; i < 16; i++) txn(vt[i].w, vt[i].a, vt[i].d, vt[i].exp, 1'b0);

        // Fill the log, then one append too many.
        for (int i = 1; i < DEPTH; i++) append(32'hA000_0000 + i, 1'b1);
        append(32'hDEAD_BEEF, 1'b0);
        rchk(LEDGER_OFF_COUNT, 32'(DEPTH));
        rchk(LEDGER_OFF_STATUS, 32'h3);
        rchk(LEDGER_OFF_HEAD, model_head);
        wreg(LEDGER_OFF_STATUS, 32'h2);
        rchk(LEDGER_OFF_STATUS, 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            wreg(LEDGER_OFF_RDIDX, 32'(i));
            rchk(LEDGER_OFF_RDDATA, (i == 0) ? 32'h1 : 32'hA000_0000 + i);
        end

        wreg(LEDGER_OFF_SEAL, 32'hA5);
        rchk(LEDGER_OFF_STATUS, 32'h5);
        append(32'h1234_5678, 1'b0);
        rchk(LEDGER_OFF_COUNT, 32'(DEPTH));
        rchk(LEDGER_OFF_STATUS, 32'h7);

        // sel held across three reads: one ack each, one IDLE cycle between.
        @(negedge clk);
        sel = 1'b1; wr = 1'b0; addr = {24'h0, LEDGER_OFF_COUNT};
        c = cyc;
        sb.push_back('{c + 1, 32'(DEPTH)});
        sb.push_back('{c + 3, 32'(DEPTH)});
        sb.push_back('{c + 5, 32'(DEPTH)});
        repeat (5) @(negedge clk);
        sel = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL held_sel pending=%0d required=0", sb.size());
            sb.delete();
        end

        // sel dropped right after sampling still completes.
        txn(1'b0, LEDGER_OFF_STATUS, 32'h0, 32'h7, 1'b1);
        txn(1'b0, LEDGER_OFF_RDDATA, 32'h0, 32'hA000_0007, 1'b1);

        // Reset while in RAM_RD: no ack may follow.
        @(negedge clk);
        sel = 1'b1; wr = 1'b0; addr = {24'h0, LEDGER_OFF_RDDATA};
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ack !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_abort ack=%b rdata=%h required ack=0 rdata=0", ack, rdata);
        end
        repeat (2) @(negedge clk);
        sel = 1'b0;
        rst = 1'b0;
        model_head = HEAD0;
        rchk(LEDGER_OFF_COUNT, 32'h0);
        rchk(LEDGER_OFF_STATUS, 32'h0);
        rchk(LEDGER_OFF_HEAD, HEAD0);
        rchk(LEDGER_OFF_RDIDX, 32'h0);

        // Sealed while empty: append refused, OVF set, FULL clear.
        wreg(LEDGER_OFF_SEAL, 32'h0000_01A5);
        append(32'h5555_5555, 1'b0);
        rchk(LEDGER_OFF_COUNT, 32'h0);
        rchk(LEDGER_OFF_STATUS, 32'h6);
        rchk(LEDGER_OFF_HEAD, model_head);

        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
